// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: datapath widths, function codes and the
// reservation-station entry record.
package tomasulo_pkg;

  localparam int DATA_W   = 8;
  localparam int TAG_W    = 3;
  localparam int FUNC_W   = 4;
  localparam int REG_W    = 4;
  localparam int RS_IDX_W = 3;
  localparam int AGE_W    = 2;

  typedef enum logic [FUNC_W-1:0] {
    FUNC_ADD = 4'b0000,
    FUNC_SUB = 4'b0001,
    FUNC_MUL = 4'b0010,
    FUNC_DIV = 4'b0011,
    FUNC_LD  = 4'b0100,
    FUNC_ST  = 4'b0101
  } func_e;

  typedef struct packed {
    logic              busy;
    logic [FUNC_W-1:0] func;
    logic [REG_W-1:0]  rd;
    logic [TAG_W-1:0]  rob;
    logic              r1;
    logic [TAG_W-1:0]  q1;
    logic [DATA_W-1:0] v1;
    logic              r2;
    logic [TAG_W-1:0]  q2;
    logic [DATA_W-1:0] v2;
    logic [AGE_W-1:0]  age;
  } rs_entry_t;

  // Age counts issues seen since this entry arrived, pinned at its maximum.
  function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] age);
    return (age == 2'd3) ? age : age + 2'd1;
  endfunction

endpackage

// File: rtl/rs_select.sv
// Oldest-ready picker: among busy entries with both operands ready the
// highest age wins, and equal ages resolve to the lower index.
module rs_select
  import tomasulo_pkg::*;
#(
  parameter int NUM_ENTRIES = 3
) (
  input  logic [NUM_ENTRIES-1:0]            busy_i,
  input  logic [NUM_ENTRIES-1:0]            ready_i,
  input  logic [NUM_ENTRIES-1:0][AGE_W-1:0] age_i,
  output logic                              valid_o,
  output logic [RS_IDX_W-1:0]               index_o
);

  logic                valid_s;
  logic [RS_IDX_W-1:0] index_s;
  logic [AGE_W-1:0]    age_s;
  logic                take_s;

  // Ascending scan; a strict greater-than keeps the lowest index on ties.
  always_comb begin
    valid_s = 1'b0;
    index_s = '0;
    age_s   = '0;
    take_s  = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      take_s  = busy_i[i] & ready_i[i] & (~valid_s | (age_i[i] > age_s));
      index_s = take_s ? RS_IDX_W'(i) : index_s;
      age_s   = take_s ? age_i[i] : age_s;
      valid_s = valid_s | take_s;
    end
  end

  assign valid_o = valid_s;
  assign index_o = index_s;

endmodule

// File: rtl/rs_dispatch.sv
// Reservation station: holds issued instructions, snoops the CDB by ROB tag
// and dispatches the oldest ready entry through registered outputs.
module rs_dispatch
  import tomasulo_pkg::*;
#(
  parameter int NUM_ENTRIES = 3,
  parameter int DATA_W      = tomasulo_pkg::DATA_W,
  parameter int TAG_W       = tomasulo_pkg::TAG_W,
  parameter int FUNC_W      = tomasulo_pkg::FUNC_W,
  parameter int REG_W       = tomasulo_pkg::REG_W
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              flush,
  input  logic              iss_valid,
  output logic              iss_ready,
  input  logic [FUNC_W-1:0] iss_func,
  input  logic [REG_W-1:0]  iss_rd,
  input  logic [TAG_W-1:0]  iss_rob,
  input  logic              iss_rdy1,
  input  logic              iss_rdy2,
  input  logic [DATA_W-1:0] iss_v1,
  input  logic [DATA_W-1:0] iss_v2,
  input  logic [TAG_W-1:0]  iss_q1,
  input  logic [TAG_W-1:0]  iss_q2,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              exec_ready,
  output logic              exec_b,
  output logic [2:0]        rs_index,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic [FUNC_W-1:0] func,
  output logic [TAG_W-1:0]  rob_ind,
  output logic [REG_W-1:0]  rd
);

  rs_entry_t ent_q [NUM_ENTRIES];
  rs_entry_t ent_d [NUM_ENTRIES];

  logic                exec_b_q;
  logic [RS_IDX_W-1:0] rs_index_q;
  logic [DATA_W-1:0]   rs1_q;
  logic [DATA_W-1:0]   rs2_q;
  logic [FUNC_W-1:0]   func_q;
  logic [TAG_W-1:0]    rob_q;
  logic [REG_W-1:0]    rd_q;

  logic [NUM_ENTRIES-1:0]            busy_s;
  logic [NUM_ENTRIES-1:0]            ready_s;
  logic [NUM_ENTRIES-1:0][AGE_W-1:0] age_s;
  logic [NUM_ENTRIES-1:0]            wake1_s;
  logic [NUM_ENTRIES-1:0]            wake2_s;
  logic                              sel_valid_s;
  logic [RS_IDX_W-1:0]               sel_idx_s;
  rs_entry_t                         sel_ent_s;
  logic                              free_found_s;
  logic [RS_IDX_W-1:0]               free_idx_s;
  logic                              iss_fire_s;
  logic                              disp_s;
  logic                              byp1_s;
  logic                              byp2_s;

  // Per-entry views of registered state; wake-ups only touch pending operands.
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      busy_s[i]  = ent_q[i].busy;
      ready_s[i] = ent_q[i].r1 & ent_q[i].r2;
      age_s[i]   = ent_q[i].age;
      wake1_s[i] = cdb_valid & ent_q[i].busy & ~ent_q[i].r1 & (ent_q[i].q1 == cdb_tag);
      wake2_s[i] = cdb_valid & ent_q[i].busy & ~ent_q[i].r2 & (ent_q[i].q2 == cdb_tag);
    end
  end

  // Lowest-index free entry; scanned downward so the lowest index lands last.
  always_comb begin
    free_found_s = 1'b0;
    free_idx_s   = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      free_idx_s   = ent_q[i].busy ? free_idx_s : RS_IDX_W'(i);
      free_found_s = free_found_s | ~ent_q[i].busy;
    end
  end

  rs_select #(
    .NUM_ENTRIES (NUM_ENTRIES)
  ) u_select (
    .busy_i  (busy_s),
    .ready_i (ready_s),
    .age_i   (age_s),
    .valid_o (sel_valid_s),
    .index_o (sel_idx_s)
  );

  assign iss_ready  = free_found_s;
  assign iss_fire_s = iss_valid & free_found_s & ~flush;
  assign disp_s     = sel_valid_s & exec_ready & ~flush;
  assign byp1_s     = cdb_valid & (iss_q1 == cdb_tag);
  assign byp2_s     = cdb_valid & (iss_q2 == cdb_tag);

  // Fields of the entry chosen by the picker.
  always_comb begin
    sel_ent_s = ent_q[0];
    for (int i = 1; i < NUM_ENTRIES; i++) begin
      sel_ent_s = (sel_idx_s == RS_IDX_W'(i)) ? ent_q[i] : sel_ent_s;
    end
  end

  // Entry next state: CDB capture, then flush > dispatch release > issue > aging.
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      ent_d[i]    = ent_q[i];
      ent_d[i].r1 = ent_q[i].r1 | wake1_s[i];
      ent_d[i].v1 = wake1_s[i] ? cdb_data : ent_q[i].v1;
      ent_d[i].r2 = ent_q[i].r2 | wake2_s[i];
      ent_d[i].v2 = wake2_s[i] ? cdb_data : ent_q[i].v2;
      if (flush) begin
        ent_d[i].busy = 1'b0;
        ent_d[i].age  = '0;
      end else if (disp_s && (sel_idx_s == RS_IDX_W'(i))) begin
        ent_d[i].busy = 1'b0;
      end else if (iss_fire_s && (free_idx_s == RS_IDX_W'(i))) begin
        ent_d[i].busy = 1'b1;
        ent_d[i].func = iss_func;
        ent_d[i].rd   = iss_rd;
        ent_d[i].rob  = iss_rob;
        ent_d[i].r1   = iss_rdy1 | byp1_s;
        ent_d[i].q1   = iss_q1;
        ent_d[i].v1   = iss_rdy1 ? iss_v1 : cdb_data;
        ent_d[i].r2   = iss_rdy2 | byp2_s;
        ent_d[i].q2   = iss_q2;
        ent_d[i].v2   = iss_rdy2 ? iss_v2 : cdb_data;
        ent_d[i].age  = '0;
      end else if (iss_fire_s && ent_q[i].busy) begin
        ent_d[i].age = age_inc(ent_q[i].age);
      end else begin
        ent_d[i].age = ent_q[i].age;
      end
    end
  end

  // Entry storage and the dispatch output registers; data outputs hold when idle.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        ent_q[i] <= '0;
      end
      exec_b_q   <= 1'b0;
      rs_index_q <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      func_q     <= '0;
      rob_q      <= '0;
      rd_q       <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        ent_q[i] <= ent_d[i];
      end
      exec_b_q <= disp_s;
      if (disp_s) begin
        rs_index_q <= sel_idx_s;
        rs1_q      <= sel_ent_s.v1;
        rs2_q      <= sel_ent_s.v2;
        func_q     <= sel_ent_s.func;
        rob_q      <= sel_ent_s.rob;
        rd_q       <= sel_ent_s.rd;
      end
    end
  end

  assign exec_b   = exec_b_q;
  assign rs_index = rs_index_q;
  assign rs1_data = rs1_q;
  assign rs2_data = rs2_q;
  assign func     = func_q;
  assign rob_ind  = rob_q;
  assign rd       = rd_q;

endmodule

// File: tb/tb_rs_dispatch.sv
// Directed and randomised bench for rs_dispatch, scored against a
// behavioural reservation-station model.
module tb_rs_dispatch;

  localparam int NE = 3;
  localparam int DW = 8;
  localparam int TW = 3;
  localparam int FW = 4;
  localparam int RW = 4;

  logic          clk1 = 1'b0;
  logic          rst, flush, iss_valid, iss_rdy1, iss_rdy2, cdb_valid, exec_ready;
  logic [FW-1:0] iss_func;
  logic [RW-1:0] iss_rd;
  logic [TW-1:0] iss_rob, iss_q1, iss_q2, cdb_tag;
  logic [DW-1:0] iss_v1, iss_v2, cdb_data;
  logic          iss_ready, exec_b;
  logic [2:0]    rs_index;
  logic [DW-1:0] rs1_data, rs2_data;
  logic [FW-1:0] func;
  logic [TW-1:0] rob_ind;
  logic [RW-1:0] rd;

  rs_dispatch #(.NUM_ENTRIES(NE), .DATA_W(DW), .TAG_W(TW), .FUNC_W(FW), .REG_W(RW)) dut (
    .clk1(clk1), .rst(rst), .flush(flush),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_func(iss_func), .iss_rd(iss_rd),
    .iss_rob(iss_rob), .iss_rdy1(iss_rdy1), .iss_rdy2(iss_rdy2), .iss_v1(iss_v1),
    .iss_v2(iss_v2), .iss_q1(iss_q1), .iss_q2(iss_q2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .exec_ready(exec_ready), .exec_b(exec_b), .rs_index(rs_index),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .func(func), .rob_ind(rob_ind), .rd(rd)
  );

  always #5 clk1 = ~clk1;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: each entry remembers the issue count at arrival; age derives from it.
  bit            m_busy [NE];
  bit            m_r1 [NE], m_r2 [NE];
  logic [DW-1:0] m_v1 [NE], m_v2 [NE];
  logic [TW-1:0] m_q1 [NE], m_q2 [NE], m_rob [NE];
  logic [FW-1:0] m_func [NE];
  logic [RW-1:0] m_rd [NE];
  int            m_stamp [NE];
  int            issue_cnt;
  logic          e_exec_b;
  logic [2:0]    e_idx;
  logic [DW-1:0] e_rs1, e_rs2;
  logic [FW-1:0] e_func;
  logic [TW-1:0] e_rob;
  logic [RW-1:0] e_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NE; i++) m_busy[i] = 1'b0;
    issue_cnt = 0;
    e_exec_b = 1'b0; e_idx = '0; e_rs1 = '0; e_rs2 = '0; e_func = '0; e_rob = '0; e_rd = '0;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; iss_valid = 1'b0; iss_rdy1 = 1'b0; iss_rdy2 = 1'b0;
    iss_func = '0; iss_rd = '0; iss_rob = '0; iss_q1 = '0; iss_q2 = '0;
    iss_v1 = '0; iss_v2 = '0; cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
  endtask

  task automatic set_issue(input logic [FW-1:0] f, input logic [RW-1:0] d, input logic [TW-1:0] r,
                           input bit rd1, input logic [DW-1:0] v1, input logic [TW-1:0] q1,
                           input bit rd2, input logic [DW-1:0] v2, input logic [TW-1:0] q2);
    iss_valid = 1'b1; iss_func = f; iss_rd = d; iss_rob = r;
    iss_rdy1 = rd1; iss_v1 = v1; iss_q1 = q1; iss_rdy2 = rd2; iss_v2 = v2; iss_q2 = q2;
  endtask

  // One clock: predict from current model + inputs, compare after the edge, advance.
  task automatic step();
    int best, best_age, a, slot;
    bit any_free, disp, fire;
    any_free = 1'b0; slot = -1;
    for (int i = 0; i < NE; i++) begin
      if (!m_busy[i]) begin
        any_free = 1'b1;
        if (slot < 0) slot = i;
      end
    end
    chk("iss_ready", {31'd0, iss_ready}, {31'd0, any_free});
    best = -1; best_age = -1;
    for (int i = 0; i < NE; i++) begin
      if (m_busy[i] && m_r1[i] && m_r2[i]) begin
        a = issue_cnt - m_stamp[i];
        if (a > 3) a = 3;
        if (a > best_age) begin best = i; best_age = a; end
      end
    end
    disp = !flush && (best >= 0) && exec_ready;
    fire = !flush && iss_valid && any_free;
    e_exec_b = disp;
    if (disp) begin
      e_idx = 3'(best); e_rs1 = m_v1[best]; e_rs2 = m_v2[best];
      e_func = m_func[best]; e_rob = m_rob[best]; e_rd = m_rd[best];
    end
    @(posedge clk1); #1;
    chk("exec_b", {31'd0, exec_b}, {31'd0, e_exec_b});
    chk("rs_index", {29'd0, rs_index}, {29'd0, e_idx});
    chk("rs1_data", {24'd0, rs1_data}, {24'd0, e_rs1});
    chk("rs2_data", {24'd0, rs2_data}, {24'd0, e_rs2});
    chk("func", {28'd0, func}, {28'd0, e_func});
    chk("rob_ind", {29'd0, rob_ind}, {29'd0, e_rob});
    chk("rd", {28'd0, rd}, {28'd0, e_rd});
    if (flush) begin
      for (int i = 0; i < NE; i++) m_busy[i] = 1'b0;
    end else begin
      for (int i = 0; i < NE; i++) begin
        if (cdb_valid && m_busy[i] && !m_r1[i] && m_q1[i] == cdb_tag) begin m_r1[i] = 1'b1; m_v1[i] = cdb_data; end
        if (cdb_valid && m_busy[i] && !m_r2[i] && m_q2[i] == cdb_tag) begin m_r2[i] = 1'b1; m_v2[i] = cdb_data; end
      end
      if (disp) m_busy[best] = 1'b0;
      if (fire) begin
        issue_cnt++;
        m_busy[slot] = 1'b1; m_stamp[slot] = issue_cnt;
        m_func[slot] = iss_func; m_rd[slot] = iss_rd; m_rob[slot] = iss_rob;
        m_q1[slot] = iss_q1; m_q2[slot] = iss_q2;
        m_r1[slot] = iss_rdy1 || (cdb_valid && iss_q1 == cdb_tag);
        m_r2[slot] = iss_rdy2 || (cdb_valid && iss_q2 == cdb_tag);
        m_v1[slot] = iss_rdy1 ? iss_v1 : cdb_data;
        m_v2[slot] = iss_rdy2 ? iss_v2 : cdb_data;
      end
    end
  endtask

  function automatic logic [TW-1:0] free_rob();
    logic [TW-1:0] t;
    bit used;
    t = TW'($urandom);
    for (int k = 0; k < 8; k++) begin
      used = 1'b0;
      for (int i = 0; i < NE; i++) if (m_busy[i] && m_rob[i] == t) used = 1'b1;
      if (!used) return t;
      t = t + 3'd1;
    end
    return t;
  endfunction

  function automatic logic [TW-1:0] pick_tag();
    int i;
    i = $urandom_range(0, NE - 1);
    if (m_busy[i] && !m_r1[i]) return m_q1[i];
    if (m_busy[i] && !m_r2[i]) return m_q2[i];
    return TW'($urandom);
  endfunction

  initial begin
    rst = 1'b0; exec_ready = 1'b0;
    idle_inputs();
    model_reset();
    #2 rst = 1'b1;
    #1;
    chk("reset_exec_b", {31'd0, exec_b}, 32'd0);
    chk("reset_iss_ready", {31'd0, iss_ready}, 32'd1);
    chk("reset_rs1_data", {24'd0, rs1_data}, 32'd0);
    chk("reset_rs_index", {29'd0, rs_index}, 32'd0);
    @(posedge clk1); #1;
    rst = 1'b0;

    // Ready issue: dispatch two edges after issue.
    exec_ready = 1'b1;
    set_issue(4'd0, 4'd2, 3'd1, 1'b1, 8'd5, 3'd0, 1'b1, 8'd3, 3'd0);
    step();
    chk("t1_no_early", {31'd0, exec_b}, 32'd0);
    idle_inputs();
    step();
    chk("t1_exec_b", {31'd0, exec_b}, 32'd1);
    chk("t1_rs1", {24'd0, rs1_data}, 32'd5);
    chk("t1_rs2", {24'd0, rs2_data}, 32'd3);
    chk("t1_rob", {29'd0, rob_ind}, 32'd1);
    chk("t1_rd", {28'd0, rd}, 32'd2);
    chk("t1_idx", {29'd0, rs_index}, 32'd0);
    step();
    chk("t1_one_shot", {31'd0, exec_b}, 32'd0);

    // CDB wake-up of operand 1.
    set_issue(4'd1, 4'd3, 3'd2, 1'b0, 8'd0, 3'd4, 1'b1, 8'd7, 3'd0);
    step();
    idle_inputs();
    step();
    chk("t2_wait_a", {31'd0, exec_b}, 32'd0);
    step();
    chk("t2_wait_b", {31'd0, exec_b}, 32'd0);
    cdb_valid = 1'b1; cdb_tag = 3'd4; cdb_data = 8'd9;
    step();
    chk("t2_wake_cycle", {31'd0, exec_b}, 32'd0);
    idle_inputs();
    step();
    chk("t2_exec_b", {31'd0, exec_b}, 32'd1);
    chk("t2_rs1", {24'd0, rs1_data}, 32'd9);
    chk("t2_rs2", {24'd0, rs2_data}, 32'd7);

    // Full and back-pressure: dispatch order follows issue order.
    exec_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_issue(4'(k), 4'(k + 8), 3'(k + 1), 1'b1, 8'(16 + k), 3'd0, 1'b1, 8'(k), 3'd0);
      step();
    end
    chk("t3_full", {31'd0, iss_ready}, 32'd0);
    set_issue(4'd5, 4'd15, 3'd5, 1'b1, 8'hEE, 3'd0, 1'b1, 8'hEE, 3'd0);
    step();
    chk("t3_backpressure", {31'd0, exec_b}, 32'd0);
    idle_inputs();
    exec_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t3_exec_b", {31'd0, exec_b}, 32'd1);
      chk("t3_order", {29'd0, rs_index}, k);
      chk("t3_rs1", {24'd0, rs1_data}, 32'(16 + k));
    end
    step();
    chk("t3_fourth_ignored", {31'd0, exec_b}, 32'd0);

    // Issue bypass from a same-cycle broadcast.
    set_issue(4'd2, 4'd6, 3'd0, 1'b1, 8'd1, 3'd0, 1'b0, 8'd0, 3'd6);
    cdb_valid = 1'b1; cdb_tag = 3'd6; cdb_data = 8'h11;
    step();
    idle_inputs();
    step();
    chk("t4_exec_b", {31'd0, exec_b}, 32'd1);
    chk("t4_rs2", {24'd0, rs2_data}, 32'h11);
    chk("t4_rs1", {24'd0, rs1_data}, 32'd1);

    // Flush together with an issue while two entries are busy.
    exec_ready = 1'b0;
    set_issue(4'd0, 4'd1, 3'd1, 1'b1, 8'd1, 3'd0, 1'b1, 8'd1, 3'd0);
    step();
    set_issue(4'd0, 4'd2, 3'd2, 1'b1, 8'd2, 3'd0, 1'b1, 8'd2, 3'd0);
    step();
    set_issue(4'd0, 4'd3, 3'd3, 1'b1, 8'd3, 3'd0, 1'b1, 8'd3, 3'd0);
    flush = 1'b1;
    step();
    chk("t5_exec_b", {31'd0, exec_b}, 32'd0);
    chk("t5_iss_ready", {31'd0, iss_ready}, 32'd1);
    idle_inputs();
    exec_ready = 1'b1;
    step();
    chk("t5_empty_a", {31'd0, exec_b}, 32'd0);
    step();
    chk("t5_empty_b", {31'd0, exec_b}, 32'd0);

    // Asynchronous reset while a dispatch is on the outputs.
    set_issue(4'd2, 4'd7, 3'd4, 1'b1, 8'h5A, 3'd0, 1'b1, 8'hA5, 3'd0);
    step();
    idle_inputs();
    step();
    chk("t6_before", {31'd0, exec_b}, 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("t6_exec_b", {31'd0, exec_b}, 32'd0);
    chk("t6_rs1", {24'd0, rs1_data}, 32'd0);
    chk("t6_rs2", {24'd0, rs2_data}, 32'd0);
    chk("t6_func", {28'd0, func}, 32'd0);
    chk("t6_rob", {29'd0, rob_ind}, 32'd0);
    chk("t6_rd", {28'd0, rd}, 32'd0);
    chk("t6_iss_ready", {31'd0, iss_ready}, 32'd1);
    model_reset();
    #2 rst = 1'b0;

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      iss_valid  = ($urandom_range(0, 99) < 60);
      iss_func   = FW'($urandom_range(0, 5));
      iss_rd     = RW'($urandom);
      iss_rob    = free_rob();
      iss_rdy1   = 1'($urandom_range(0, 1));
      iss_rdy2   = 1'($urandom_range(0, 1));
      iss_v1     = DW'($urandom);
      iss_v2     = DW'($urandom);
      iss_q1     = TW'($urandom);
      iss_q2     = TW'($urandom);
      cdb_valid  = ($urandom_range(0, 99) < 50);
      cdb_tag    = pick_tag();
      cdb_data   = DW'($urandom);
      exec_ready = ($urandom_range(0, 99) < 70);
      flush      = ($urandom_range(0, 99) < 3);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rs_dispatch.md
# rs_dispatch

Reservation-station-and-dispatch unit that feeds the execution stage of the Tomasulo pipeline. It holds issued instructions whose operands may still be pending, snoops the common data bus (CDB) for results by ROB tag, and sends the oldest fully ready instruction to the execution unit with a one-cycle `exec_b` strobe. It drives exactly the signals the execution unit consumes: `rs_index`, `rs1_data`, `rs2_data`, `func`, `rob_ind` and `rd`.

## Interface
Parameters:
- `NUM_ENTRIES`, 3: reservation-station depth.
- `DATA_W`, 8: operand width.
- `TAG_W`, 3: ROB index width.
- `FUNC_W`, 4: function code width.
- `REG_W`, 4: destination register width.

Ports:
- `clk1` in 1: the single clock. All state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous clear of all entries.
- `iss_valid` in 1: issue request.
- `iss_ready` out 1: at least one free entry.
- `iss_func` in FUNC_W: operation code.
- `iss_rd` in REG_W: destination register.
- `iss_rob` in TAG_W: ROB slot of the instruction.
- `iss_rdy1`, `iss_rdy2` in 1: operand already valid.
- `iss_v1`, `iss_v2` in DATA_W: operand values, used when the matching `iss_rdy*` is 1.
- `iss_q1`, `iss_q2` in TAG_W: producer ROB tags, used when the matching `iss_rdy*` is 0.
- `cdb_valid` in 1: a result broadcast is present.
- `cdb_tag` in TAG_W: ROB tag of the broadcast.
- `cdb_data` in DATA_W: broadcast value.
- `exec_ready` in 1: the execution unit can accept an operation this cycle.
- `exec_b` out 1: one-cycle dispatch strobe.
- `rs_index` out 3: entry number being dispatched.
- `rs1_data`, `rs2_data` out DATA_W: operand values.
- `func` out FUNC_W, `rob_ind` out TAG_W, `rd` out REG_W: fields of the dispatched instruction.

## Operation
- **Entry contents:** busy, func, rd, rob, V1/Q1/R1, V2/Q2/R2, and a 2-bit age.
- **Issue:** fires when `iss_valid & iss_ready`.
  - The instruction is written into the lowest-index free entry with age 0.
  - The age of every other busy entry increments, saturating at 3.
- **Issue bypass:** a pending issue operand whose `iss_q` equals `cdb_tag` while `cdb_valid` is high is written as ready, with V = `cdb_data`.
- **CDB capture:** for each busy entry and each operand with R=0 and Q == `cdb_tag`, `cdb_valid` sets R=1 and V=`cdb_data`. One broadcast may wake any number of operands.
- **Select:**
  - Candidates are busy entries with R1 & R2 both set in registered state.
  - The highest age wins; ties go to the lower index.
  - Operands woken by the CDB in the current cycle are not candidates until the next cycle.
- **Dispatch:** when a candidate exists and `exec_ready` is 1:
  - the output registers load that entry's fields;
  - `exec_b` is driven 1;
  - the entry's busy bit clears.
- **No dispatch:** otherwise `exec_b` is 0 and the data outputs hold their last values.
- **`iss_ready`:** equals the OR of the not-busy bits in registered state. An entry freed by a dispatch in the same cycle does not count as free until the next cycle.
- **Issue and dispatch together:** they target different entries and both take effect in the same cycle.
- **Flush:** clears every busy bit and drives `exec_b` to 0 at the next edge. It has priority over issue, dispatch and CDB capture.
- **ROB tags:** unique among busy entries; the unit does not check this.

## Timing
- **Reset values (while `rst` is high):** all busy bits 0, all ages 0, `exec_b` 0, every data output 0, `iss_ready` 1.
- **Reset mid-operation:** discards all entries immediately and asynchronously.
- **Issue to dispatch:** for an instruction issued with both operands ready at edge E0, the earliest dispatch sets `exec_b` high after edge E1.
- **CDB to dispatch:** for an operand woken by the CDB at edge E0, the earliest `exec_b` is after edge E1.
- **Throughput:** at most one dispatch per cycle. `exec_b` is never high two cycles in a row for the same entry.
- **Back-pressure:** with `exec_ready` held at 0, entries stay in place. Dispatch resumes on the first cycle `exec_ready` is 1.
- **Full:** with all `NUM_ENTRIES` entries busy, `iss_ready` is 0 and `iss_valid` is ignored.

## Structure
- **Shared package `tomasulo_pkg`:**
  - width constants `DATA_W`, `TAG_W`, `FUNC_W`, `REG_W`;
  - func codes: ADD 0000, SUB 0001, MUL 0010, DIV 0011, LD 0100, ST 0101;
  - the reservation-station entry record type.
- **Sub-module `rs_select`:** a combinational oldest-ready picker that takes busy, ready and age vectors and returns a valid flag and an index.

## Test plan
- **Ready issue:** issue func=0000, rd=2, rob=1, v1=5, v2=3, both ready, `exec_ready`=1. Required: `exec_b`=1 two edges later with `rs1_data`=5, `rs2_data`=3, `rob_ind`=1, `rd`=2, `rs_index`=0.
- **CDB wake-up:** issue with q1=4 pending and v2=7, then `cdb_valid`, tag=4, data=9. Required: dispatch on the following cycle with `rs1_data`=9; no dispatch before the broadcast.
- **Full and back-pressure:** fill 3 entries with `exec_ready`=0. Required: `iss_ready`=0 and a 4th issue is ignored. Then raise `exec_ready`: dispatch order is the issue order (rs_index 0, 1, 2) on consecutive cycles.
- **Issue bypass:** issue with q2=6 in the same cycle as a CDB broadcast with tag=6, data=0x11. Required: the entry is ready and `rs2_data`=0x11 at dispatch.
- **Flush with issue:** with `flush` and `iss_valid` asserted together while 2 entries are busy, required: all entries empty, `exec_b` stays 0, `iss_ready`=1.
- **Asynchronous reset:** assert `rst` between clock edges while `exec_b`=1. Required: `exec_b` and all outputs are 0 immediately, before the next edge.
